// File: rtl/tape_pkg.sv
// Shared tape transport encodings and position width, used by the controller and the overlay.
package tape_pkg;

    localparam int unsigned POS_W = 24;

    typedef logic [POS_W-1:0] pos_t;
    typedef logic [POS_W:0]   pos_ext_t;

    typedef enum logic [1:0] {
        CMD_STOP = 2'd0,
        CMD_PLAY = 2'd1,
        CMD_FF   = 2'd2,
        CMD_REW  = 2'd3
    } cmd_e;

endpackage

// File: rtl/tick_div.sv
// Free-running tick divider: one tick every div_i+1 clocks, restarted by clr_i.
module tick_div (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        clr_i,
    input  logic [31:0] div_i,
    output logic        tick_o
);

    logic [31:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == div_i);

    always_comb begin
        cnt_d = cnt_q + 32'd1;
        if (clr_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tape_transport_ctrl.sv
// Tape transport controller: STOP/PLAY/FF/REW with reversal dead-time and position tracking.
module tape_transport_ctrl
    import tape_pkg::*;
#(
    parameter int unsigned PLAY_DIV   = 6666,
    parameter int unsigned WIND_DIV   = 833,
    parameter int unsigned FAST_STEP  = 8,
    parameter int unsigned SETTLE_CYC = 64
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd,
    input  logic [POS_W-1:0] tape_end,
    input  logic             loop_en,
    output logic [POS_W-1:0] pos,
    output logic [1:0]       mode,
    output logic             motor,
    output logic             at_end,
    output logic             at_start
);

    // Motion states share their code with the command that selects them.
    localparam logic [2:0] ST_STOP   = 3'd0;
    localparam logic [2:0] ST_PLAY   = 3'd1;
    localparam logic [2:0] ST_FF     = 3'd2;
    localparam logic [2:0] ST_REW    = 3'd3;
    localparam logic [2:0] ST_SETTLE = 3'd4;

    localparam logic [31:0] PLAY_DIV_W = 32'(PLAY_DIV);
    localparam logic [31:0] WIND_DIV_W = 32'(WIND_DIV);
    localparam logic [31:0] SETTLE_END = 32'(SETTLE_CYC - 1);
    localparam pos_ext_t    STEP_W     = pos_ext_t'(FAST_STEP);

    logic [2:0]  state_q, state_d;
    logic [1:0]  target_q, target_d;
    logic [31:0] settle_q, settle_d;
    pos_t        pos_q, pos_d;
    logic [1:0]  mode_q, mode_d;
    logic        motor_q, motor_d;
    logic        at_end_q, at_end_d;
    logic        at_start_q, at_start_d;

    logic        cmd_acc;
    logic        tick;
    logic        div_clr;
    logic [31:0] div_sel;
    pos_ext_t    ff_sum;

    assign cmd_ready = (state_q != ST_SETTLE);
    assign cmd_acc   = cmd_valid && cmd_ready;
    assign ff_sum    = {1'b0, pos_q} + STEP_W;
    assign div_sel   = (state_q == ST_PLAY) ? PLAY_DIV_W : WIND_DIV_W;
    // Hold the divider at zero outside motion and restart it on every entry.
    assign div_clr   = (state_d == ST_STOP) || (state_d == ST_SETTLE) || (state_d != state_q);

    tick_div u_tick_div (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .clr_i   (div_clr),
        .div_i   (div_sel),
        .tick_o  (tick)
    );

    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        settle_d   = settle_q;
        pos_d      = pos_q;
        at_end_d   = 1'b0;
        at_start_d = 1'b0;

        if (tape_end < pos_q) begin
            pos_d = tape_end;
        end else if (tick) begin
            case (state_q)
                ST_PLAY: begin
                    if (pos_q < tape_end) begin
                        pos_d = pos_q + pos_t'(1);
                    end else begin
                        at_end_d = 1'b1;
                        if (loop_en) begin
                            pos_d = '0;
                        end else begin
                            state_d = ST_STOP;
                        end
                    end
                end
                ST_FF: begin
                    if (ff_sum >= {1'b0, tape_end}) begin
                        pos_d    = tape_end;
                        state_d  = ST_STOP;
                        at_end_d = 1'b1;
                    end else begin
                        pos_d = ff_sum[POS_W-1:0];
                    end
                end
                ST_REW: begin
                    if ({1'b0, pos_q} <= STEP_W) begin
                        pos_d      = '0;
                        state_d    = ST_STOP;
                        at_start_d = 1'b1;
                    end else begin
                        pos_d = pos_q - STEP_W[POS_W-1:0];
                    end
                end
                default: ;
            endcase
        end

        if (state_q == ST_SETTLE) begin
            if (settle_q == SETTLE_END) begin
                state_d  = {1'b0, target_q};
                settle_d = '0;
            end else begin
                settle_d = settle_q + 32'd1;
            end
        end else if (cmd_acc) begin
            if (cmd == CMD_STOP) begin
                state_d = ST_STOP;
            end else if ({1'b0, cmd} == state_q) begin
                state_d = state_d;
            end else if (state_q == ST_STOP) begin
                state_d = {1'b0, cmd};
            end else begin
                state_d  = ST_SETTLE;
                target_d = cmd;
                settle_d = '0;
            end
        end

        mode_d  = (state_d == ST_SETTLE) ? 2'd0 : state_d[1:0];
        motor_d = (state_d != ST_STOP) && (state_d != ST_SETTLE);
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_STOP;
            target_q   <= CMD_STOP;
            settle_q   <= '0;
            pos_q      <= '0;
            mode_q     <= 2'd0;
            motor_q    <= 1'b0;
            at_end_q   <= 1'b0;
            at_start_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            settle_q   <= settle_d;
            pos_q      <= pos_d;
            mode_q     <= mode_d;
            motor_q    <= motor_d;
            at_end_q   <= at_end_d;
            at_start_q <= at_start_d;
        end
    end

    assign pos      = pos_q;
    assign mode     = mode_q;
    assign motor    = motor_q;
    assign at_end   = at_end_q;
    assign at_start = at_start_q;

endmodule

// File: tb/tb_tape_transport_ctrl.sv
// Scoreboard bench for tape_transport_ctrl: expected position events queued at stimulus time.
module tb_tape_transport_ctrl;

    localparam int unsigned PDIV   = 24;
    localparam int unsigned WDIV   = 9;
    localparam int unsigned STEP   = 8;
    localparam int unsigned SETTLE = 64;
    localparam int unsigned PPER   = PDIV + 1;
    localparam int unsigned WPER   = WDIV + 1;

    typedef struct {
        logic [23:0] pos;
        logic [1:0]  mode;
        logic        ae;
        logic        as;
        int unsigned cyc;
    } ev_t;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd = 2'd0;
    logic [23:0] tape_end = 24'd0;
    logic        loop_en = 1'b0;
    logic [23:0] pos;
    logic [1:0]  mode;
    logic        motor;
    logic        at_end;
    logic        at_start;

    int unsigned cyc = 0;
    int unsigned acc;
    int          n_checks = 0;
    int          n_errors = 0;
    ev_t         exp_q[$];
    logic [23:0] prev_pos = 24'd0;

    tape_transport_ctrl #(
        .PLAY_DIV   (PDIV),
        .WIND_DIV   (WDIV),
        .FAST_STEP  (STEP),
        .SETTLE_CYC (SETTLE)
    ) dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd       (cmd),
        .tape_end  (tape_end),
        .loop_en   (loop_en),
        .pos       (pos),
        .mode      (mode),
        .motor     (motor),
        .at_end    (at_end),
        .at_start  (at_start)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_ev(input int p, input int m, input int ae, input int as, input int unsigned c);
        ev_t e;
        e.pos  = 24'(p);
        e.mode = 2'(m);
        e.ae   = 1'(ae);
        e.as   = 1'(as);
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    // Any position change or end pulse is a DUT event and must match the queue head.
    always @(negedge clk_sys) begin
        if (reset_n && (pos != prev_pos || at_end || at_start)) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_event_pos", 32'(pos), 32'(prev_pos));
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                check_eq("ev_pos", 32'(pos), 32'(e.pos));
                check_eq("ev_mode", 32'(mode), 32'(e.mode));
                check_eq("ev_at_end", 32'(at_end), 32'(e.ae));
                check_eq("ev_at_start", 32'(at_start), 32'(e.as));
                check_eq("ev_cycle", cyc, e.cyc);
            end
        end
        prev_pos = pos;
    end

    task automatic send(input logic [1:0] c);
        @(negedge clk_sys);
        cmd_valid = 1'b1;
        cmd       = c;
        @(posedge clk_sys);
        #1;
        acc       = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic drain(input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk_sys);
        end
        check_eq("drain_left", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        int lows;
        int bad;

        #12;
        check_eq("rst_pos", 32'(pos), 32'd0);
        check_eq("rst_mode", 32'(mode), 32'd0);
        check_eq("rst_motor", 32'(motor), 32'd0);
        check_eq("rst_at_end", 32'(at_end), 32'd0);
        check_eq("rst_at_start", 32'(at_start), 32'd0);
        check_eq("rst_ready", 32'(cmd_ready), 32'd1);
        tape_end = 24'd3;
        @(negedge clk_sys);
        reset_n = 1'b1;
        repeat (3) @(posedge clk_sys);

        // PLAY to the end without looping.
        send(2'd1);
        check_eq("play_mode", 32'(mode), 32'd1);
        check_eq("play_motor", 32'(motor), 32'd1);
        push_ev(1, 1, 0, 0, acc + PPER);
        push_ev(2, 1, 0, 0, acc + 2 * PPER);
        push_ev(3, 1, 0, 0, acc + 3 * PPER);
        push_ev(3, 0, 1, 0, acc + 4 * PPER);
        drain(200);
        check_eq("end_motor", 32'(motor), 32'd0);

        // Rewind to 0, then PLAY with looping.
        send(2'd3);
        push_ev(0, 0, 0, 1, acc + WPER);
        drain(50);
        loop_en = 1'b1;
        send(2'd1);
        push_ev(1, 1, 0, 0, acc + PPER);
        push_ev(2, 1, 0, 0, acc + 2 * PPER);
        push_ev(3, 1, 0, 0, acc + 3 * PPER);
        push_ev(0, 1, 1, 0, acc + 4 * PPER);
        push_ev(1, 1, 0, 0, acc + 5 * PPER);
        drain(300);
        send(2'd0);
        check_eq("stop_mode", 32'(mode), 32'd0);
        check_eq("stop_motor", 32'(motor), 32'd0);

        // FF to a clipped end, then REW to the start.
        loop_en  = 1'b0;
        tape_end = 24'd20;
        send(2'd3);
        push_ev(0, 0, 0, 1, acc + WPER);
        drain(50);
        send(2'd2);
        push_ev(8, 2, 0, 0, acc + WPER);
        push_ev(16, 2, 0, 0, acc + 2 * WPER);
        push_ev(20, 0, 1, 0, acc + 3 * WPER);
        drain(100);
        send(2'd3);
        push_ev(12, 3, 0, 0, acc + WPER);
        push_ev(4, 3, 0, 0, acc + 2 * WPER);
        push_ev(0, 0, 0, 1, acc + 3 * WPER);
        drain(100);

        // PLAY then FF: dead-time, with a command ignored while not ready.
        send(2'd1);
        repeat (4) @(posedge clk_sys);
        send(2'd2);
        lows = 0;
        bad  = 0;
        for (int i = 0; i < SETTLE; i++) begin
            if (!cmd_ready) lows++;
            if (mode != 2'd0 || motor) bad++;
            if (i == 10) begin
                cmd_valid = 1'b1;
                cmd       = 2'd3;
            end
            if (i == 12) cmd_valid = 1'b0;
            @(posedge clk_sys);
            #1;
        end
        check_eq("settle_low_cycles", 32'(lows), SETTLE);
        check_eq("settle_outputs_bad", 32'(bad), 32'd0);
        check_eq("settle_ready_after", 32'(cmd_ready), 32'd1);
        check_eq("settle_mode_after", 32'(mode), 32'd2);
        push_ev(8, 2, 0, 0, cyc + WPER);
        push_ev(16, 2, 0, 0, cyc + 2 * WPER);
        push_ev(20, 0, 1, 0, cyc + 3 * WPER);
        drain(100);

        // Long FF run to 500.
        tape_end = 24'd500;
        send(2'd2);
        for (int k = 1; k <= 60; k++) begin
            push_ev(20 + 8 * k, (k == 60) ? 0 : 2, (k == 60) ? 1 : 0, 0, acc + k * WPER);
        end
        drain(1000);

        // Shrinking tape_end under PLAY clamps without an end pulse.
        tape_end = 24'd1000;
        send(2'd1);
        repeat (10) @(posedge clk_sys);
        #1;
        tape_end = 24'd100;
        push_ev(100, 1, 0, 0, acc + 11);
        push_ev(100, 0, 1, 0, acc + PPER);
        drain(100);

        // Repeated PLAY keeps the divider phase.
        tape_end = 24'd1000;
        send(2'd1);
        push_ev(101, 1, 0, 0, acc + PPER);
        push_ev(102, 1, 0, 0, acc + 2 * PPER);
        repeat (8) @(posedge clk_sys);
        send(2'd1);
        check_eq("replay_mode", 32'(mode), 32'd1);
        drain(100);
        send(2'd0);
        check_eq("stop2_mode", 32'(mode), 32'd0);

        // tape_end == 0: clamp, then FF and PLAY stop on first tick.
        @(negedge clk_sys);
        tape_end = 24'd0;
        push_ev(0, 0, 0, 0, cyc + 1);
        drain(10);
        send(2'd2);
        push_ev(0, 0, 1, 0, acc + WPER);
        drain(50);
        send(2'd1);
        push_ev(0, 0, 1, 0, acc + PPER);
        drain(50);

        // Asynchronous reset in the middle of a settle period.
        tape_end = 24'd50;
        send(2'd2);
        for (int k = 1; k <= 7; k++) begin
            push_ev((k == 7) ? 50 : 8 * k, (k == 7) ? 0 : 2, (k == 7) ? 1 : 0, 0, acc + k * WPER);
        end
        drain(200);
        tape_end = 24'd100;
        send(2'd1);
        repeat (2) @(posedge clk_sys);
        send(2'd3);
        repeat (10) @(posedge clk_sys);
        #3;
        check_eq("pre_rst_ready", 32'(cmd_ready), 32'd0);
        reset_n = 1'b0;
        #1;
        check_eq("arst_pos", 32'(pos), 32'd0);
        check_eq("arst_mode", 32'(mode), 32'd0);
        check_eq("arst_motor", 32'(motor), 32'd0);
        check_eq("arst_ready", 32'(cmd_ready), 32'd1);
        check_eq("arst_at_end", 32'(at_end), 32'd0);
        check_eq("arst_at_start", 32'(at_start), 32'd0);
        repeat (2) @(negedge clk_sys);
        reset_n = 1'b1;
        repeat (200) @(posedge clk_sys);
        #1;
        check_eq("post_rst_mode", 32'(mode), 32'd0);
        check_eq("post_rst_motor", 32'(motor), 32'd0);
        check_eq("post_rst_pos", 32'(pos), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tape_transport_ctrl.md
TAPE_TRANSPORT_CTRL -- requirements
Module: tape_transport_ctrl

Interface
REQ-001 Parameter PLAY_DIV, default 6666: a play tick occurs once every PLAY_DIV+1 clocks.
REQ-002 Parameter WIND_DIV, default 833: a wind tick occurs once every WIND_DIV+1 clocks.
REQ-003 Parameter FAST_STEP, default 8: position increment per wind tick in FF and REW.
REQ-004 Parameter SETTLE_CYC, default 64: motor reversal dead-time in clocks.
REQ-005 clk_sys  input  1  sole clock; all logic on its rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 cmd_valid  input  1  command request.
REQ-008 cmd_ready  output  1  command accepted when cmd_valid and cmd_ready are both high in a cycle.
REQ-009 cmd  input  2  command code: 0 STOP, 1 PLAY, 2 FF, 3 REW.
REQ-010 tape_end  input  24  last valid position, sampled every cycle.
REQ-011 loop_en  input  1  PLAY wraps to 0 at tape_end instead of stopping.
REQ-012 pos  output  24  current tape position, driven to the overlay pos/max pair.
REQ-013 mode  output  2  current state code: 0 STOP, 1 PLAY, 2 FF, 3 REW (SETTLE reports 0).
REQ-014 motor  output  1  high in PLAY, FF and REW.
REQ-015 at_end  output  1  one-cycle pulse when pos reaches tape_end and motion stops or wraps.
REQ-016 at_start  output  1  one-cycle pulse when REW reaches 0.

Function
REQ-017 The state machine SHALL have the states STOP, SETTLE, PLAY, FF and REW.
REQ-018 cmd_ready SHALL be high in every state except SETTLE.
REQ-019 An accepted STOP command SHALL enter STOP on the next clock with no settle period.
REQ-020 An accepted PLAY, FF or REW command issued from STOP SHALL enter the commanded state on the next clock.
REQ-021 An accepted motion command that differs from the current motion state SHALL enter SETTLE for exactly SETTLE_CYC clocks, latch the target state, and then enter the target state.
REQ-022 An accepted command equal to the current state SHALL be a no-op: no settle, and the divider SHALL not restart.
REQ-023 The tick divider SHALL clear to 0 on every entry into PLAY, FF or REW, so the first tick falls PLAY_DIV+1 or WIND_DIV+1 clocks after entry.
REQ-024 On each play tick in PLAY with pos < tape_end, pos SHALL increment by 1.
REQ-025 On a play tick in PLAY with pos == tape_end and loop_en=1: pos SHALL go to 0, the state SHALL stay PLAY, and at_end SHALL pulse.
REQ-026 On a play tick in PLAY with pos == tape_end and loop_en=0: pos SHALL hold, the state SHALL become STOP, and at_end SHALL pulse.
REQ-027 On each wind tick in FF, pos SHALL become min(pos+FAST_STEP, tape_end), computed 25 bits wide with no wrap; on reaching tape_end the state SHALL become STOP and at_end SHALL pulse in the same cycle.
REQ-028 On each wind tick in REW, pos SHALL become max(pos-FAST_STEP, 0), with no underflow; on reaching 0 the state SHALL become STOP and at_start SHALL pulse.
REQ-029 If tape_end < pos in any state, pos SHALL be clamped to tape_end on the next clock; this clamp SHALL take priority over a tick and SHALL NOT pulse at_end.
REQ-030 If tape_end == 0, PLAY with loop_en=0 SHALL stop at the first tick, and FF SHALL stop at the first tick.
REQ-031 pos, mode and motor SHALL be registered outputs; at_end and at_start SHALL be registered single-cycle pulses.
REQ-032 Any command with cmd_valid high while cmd_ready is low SHALL be ignored, not queued.

Reset
REQ-033 While reset_n is low: state = STOP, pos = 0, divider = 0, settle counter = 0, mode = 0, motor = 0, at_end = 0, at_start = 0, cmd_ready = 1.
REQ-034 Reset asserted mid-SETTLE or mid-motion SHALL discard the latched target state; after release the block SHALL wait in STOP for a command.

Structure
REQ-035 The command/state encodings (STOP, PLAY, FF, REW) and the 24-bit position width SHALL live in a shared package tape_pkg, also used by the overlay.
REQ-036 The divider SHALL be one sub-module, tick_div, that takes the divisor selected by state and a clear input and outputs a tick.

Verification
REQ-037 Reset release, then PLAY with tape_end=3 and loop_en=0 -> pos steps 1,2,3 at 6667-clock spacing; at the next tick at_end pulses, mode=0 and pos=3.
REQ-038 The same stimulus with loop_en=1 -> pos sequence 1,2,3,0,1, with at_end pulsing on the 3->0 step and mode staying 1.
REQ-039 FF from pos=0 with tape_end=20 -> pos 8,16,20 at 834-clock spacing, at_end pulses on reaching 20, mode=0; a following REW -> pos 12,4,0 and at_start pulses.
REQ-040 PLAY, then FF accepted -> cmd_ready low for exactly 64 clocks with mode=0 and motor=0, then mode=2; STOP during PLAY -> mode=0 on the next clock.
REQ-041 PLAY at pos=500, then drive tape_end to 100 -> pos=100 on the next clock with no at_end pulse; PLAY command while in PLAY -> divider phase unchanged.
REQ-042 Assert reset_n low mid-SETTLE -> all outputs take their reset values immediately (asynchronously); after release mode stays 0 with no motion.
